// File: rtl/cdc_pulse_tx_ctrl_pkg.sv
// Shared definitions for the req/ack pulse-crossing source controller.
package cdc_pulse_tx_ctrl_pkg;

    // Clock edges between an ack_in change and its appearance on ack_s.
    localparam int SYNC_LAT = 3;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } state_e;

endpackage

// File: rtl/cdc_pulse_tx_ctrl_sync.sv
// Library 3-stage set-type synchronizer: all stages are forced to 1 while
// set_ is low, so the far side reads as busy out of reset.
module p_SSYNC3DO_S_PPP (
    input  logic clk,
    input  logic set_,
    input  logic d,
    output logic q
);

    logic [2:0] sync_q;

    // Shift the asynchronous input through three flops.
    always_ff @(posedge clk or negedge set_) begin
        if (!set_) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign q = sync_q[2];

endmodule

// File: rtl/cdc_pulse_tx_ctrl.sv
// Source-side controller for a 4-phase req/ack crossing: counts local event
// pulses and runs one full handshake per pending event.
module cdc_pulse_tx_ctrl
    import cdc_pulse_tx_ctrl_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int TO_W  = 8
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             pulse_in,
    input  logic             ack_in,
    output logic             req_out,
    output logic             done_pulse,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             idle,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             tmo,
    input  logic             tmo_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0]  TO_MAX  = '1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_MAX - TO_W'(1);

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic [TO_W-1:0]  wd_q, wd_d;
    logic             ack_s;
    logic             launch;
    logic             sat;
    logic             inc;
    logic             in_req;
    logic             stay;

    p_SSYNC3DO_S_PPP u_ack_sync (
        .clk  (clk),
        .set_ (reset_),
        .d    (ack_in),
        .q    (ack_s)
    );

    // Next-state and request level; only the synchronized ack is used.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d = state_q;
        req_d   = req_q;
        done_d  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            INIT: begin
                req_d = 1'b0;
                if (!ack_s) state_d = IDLE;
            end
            IDLE: begin
                req_d = 1'b0;
                if (cnt_q != '0 || pulse_in) begin
                    state_d = REQ_HI;
                    req_d   = 1'b1;
                    launch  = 1'b1;
                end
            end
            REQ_HI: begin
                req_d = 1'b1;
                if (ack_s) begin
                    state_d = REQ_LO;
                    req_d   = 1'b0;
                end
            end
            REQ_LO: begin
                req_d = 1'b0;
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = INIT;
                req_d   = 1'b0;
            end
        endcase
    end

    // Pending counter, sticky flags and handshake watchdog.
    always_comb begin
        sat    = (cnt_q == CNT_MAX);
        // A saturated counter still accepts the event when one leaves the same cycle.
        inc    = pulse_in && (!sat || launch);
        cnt_d  = cnt_q + CNT_W'(inc) - CNT_W'(launch);
        ovf_d  = (ovf_q && !ovf_clr) || (pulse_in && sat && !launch);

        in_req = (state_q == REQ_HI) || (state_q == REQ_LO);
        stay   = (state_d == state_q);
        wd_d   = '0;
        if (in_req && stay) begin
            wd_d = (wd_q == TO_MAX) ? wd_q : wd_q + TO_W'(1);
        end
        // Set only on the step into all-ones so a clear while stalled sticks.
        tmo_d  = (tmo_q && !tmo_clr) || (in_req && stay && wd_q == TO_LAST);
    end

    // State register and request/done flops.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= INIT;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
            wd_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            tmo_q <= tmo_d;
            wd_q  <= wd_d;
        end
    end

    assign req_out    = req_q;
    assign done_pulse = done_q;
    assign pend_cnt   = cnt_q;
    assign ovf        = ovf_q;
    assign tmo        = tmo_q;
    assign idle       = (state_q == IDLE) && (cnt_q == '0);

endmodule

// File: tb/tb_cdc_pulse_tx_ctrl.sv
// Directed bench: instance A (default widths) with a far-side ack model,
// instance B (CNT_W=2, TO_W=4) with a bench-driven ack for overflow/timeout.
module tb_cdc_pulse_tx_ctrl;
    import cdc_pulse_tx_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A
    logic       a_reset_ = 1'b0;
    logic       a_pulse = 1'b0, a_ovf_clr = 1'b0, a_tmo_clr = 1'b0;
    logic       a_ack_in, a_req, a_done, a_idle, a_ovf, a_tmo;
    logic [3:0] a_pend;
    logic       a_far_en = 1'b1;
    logic       a_man_ack = 1'b0;

    // Instance B
    logic       b_reset_ = 1'b0;
    logic       b_pulse = 1'b0, b_ovf_clr = 1'b0, b_tmo_clr = 1'b0;
    logic       b_ack_in = 1'b0;
    logic       b_req, b_done, b_idle, b_ovf, b_tmo;
    logic [1:0] b_pend;

    cdc_pulse_tx_ctrl #(.CNT_W(4), .TO_W(8)) dut_a (
        .clk(clk), .reset_(a_reset_), .pulse_in(a_pulse), .ack_in(a_ack_in),
        .req_out(a_req), .done_pulse(a_done), .pend_cnt(a_pend), .idle(a_idle),
        .ovf(a_ovf), .ovf_clr(a_ovf_clr), .tmo(a_tmo), .tmo_clr(a_tmo_clr)
    );

    cdc_pulse_tx_ctrl #(.CNT_W(2), .TO_W(4)) dut_b (
        .clk(clk), .reset_(b_reset_), .pulse_in(b_pulse), .ack_in(b_ack_in),
        .req_out(b_req), .done_pulse(b_done), .pend_cnt(b_pend), .idle(b_idle),
        .ovf(b_ovf), .ovf_clr(b_ovf_clr), .tmo(b_tmo), .tmo_clr(b_tmo_clr)
    );

    // Far side for A: ack follows req, changing 2 cycles after req changes.
    logic far_d1 = 1'b0, far_d2 = 1'b0, far_ack = 1'b0;
    always @(negedge clk) begin
        far_ack <= far_d2;
        far_d2  <= far_d1;
        far_d1  <= a_req;
    end
    assign a_ack_in = a_far_en ? far_ack : a_man_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge: outputs are stable, inputs may change.
    task automatic tick();
        @(negedge clk);
    endtask

    int rises, dones, maxp;
    logic prev_req;

    initial begin
        // ---------------- reset and INIT -> IDLE ----------------
        tick(); tick();
        check("rst_a_req",  32'(a_req),  0);
        check("rst_a_done", 32'(a_done), 0);
        check("rst_a_pend", 32'(a_pend), 0);
        check("rst_a_ovf",  32'(a_ovf),  0);
        check("rst_a_tmo",  32'(a_tmo),  0);
        check("rst_a_idle", 32'(a_idle), 0);
        check("rst_b_idle", 32'(b_idle), 0);
        a_reset_ = 1'b1;
        b_reset_ = 1'b1;
        for (int i = 1; i <= SYNC_LAT + 1; i++) begin
            tick();
            check($sformatf("init_idle_c%0d", i), 32'(a_idle), 32'(i == SYNC_LAT + 1));
            check($sformatf("init_req_c%0d", i),  32'(a_req),  0);
        end

        // ---------------- single handshake ----------------
        a_pulse = 1'b1;                      // cycle t
        for (int i = 1; i <= 16; i++) begin
            tick();
            a_pulse = 1'b0;
            check($sformatf("hs_req_t%0d", i),  32'(a_req),  32'(i >= 1 && i <= 6));
            check($sformatf("hs_done_t%0d", i), 32'(a_done), 32'(i == 13));
            check($sformatf("hs_pend_t%0d", i), 32'(a_pend), 0);
        end
        check("hs_idle_end", 32'(a_idle), 1);

        // ---------------- burst of 5 ----------------
        rises = 0; dones = 0; maxp = 0;
        prev_req = a_req;
        for (int i = 0; i < 120; i++) begin
            a_pulse = (i < 5);
            tick();
            if (a_req && !prev_req) rises++;
            prev_req = a_req;
            if (a_done) dones++;
            if (int'(a_pend) > maxp) maxp = int'(a_pend);
        end
        a_pulse = 1'b0;
        check("burst_peak",  32'(maxp),   4);
        check("burst_rises", 32'(rises),  5);
        check("burst_dones", 32'(dones),  5);
        check("burst_ovf",   32'(a_ovf),  0);
        check("burst_tmo",   32'(a_tmo),  0);
        check("burst_idle",  32'(a_idle), 1);
        check("burst_pend",  32'(a_pend), 0);

        // ---------------- overflow on B (ack held 0) ----------------
        check("b_idle_pre", 32'(b_idle), 1);
        for (int i = 0; i < 6; i++) begin    // pulses in cycles k..k+5
            b_pulse = 1'b1;
            tick();
        end                                  // now cycle k+6
        check("ovf_pend", 32'(b_pend), 3);
        check("ovf_flag", 32'(b_ovf),  1);
        check("ovf_req",  32'(b_req),  1);
        b_ovf_clr = 1'b1;                    // 7th pulse with clear: set wins
        tick();                              // k+7
        check("ovf_setwins", 32'(b_ovf),  1);
        check("ovf_pend7",   32'(b_pend), 3);
        b_pulse = 1'b0;                      // lone clear
        tick();                              // k+8
        b_ovf_clr = 1'b0;
        check("ovf_cleared", 32'(b_ovf),  0);

        // ---------------- timeout on B (REQ_HI entered at k+1) ----------------
        for (int i = 0; i < 7; i++) tick();  // k+15
        check("tmo_before", 32'(b_tmo), 0);
        tick();                              // k+16
        check("tmo_set",    32'(b_tmo), 1);
        check("tmo_req",    32'(b_req), 1);
        b_ack_in = 1'b1;
        tick(); tick(); tick();              // k+19
        check("tmo_req_hold", 32'(b_req), 1);
        tick();                              // k+20
        check("tmo_req_drop", 32'(b_req), 0);
        b_ack_in = 1'b0;
        tick(); tick(); tick();              // k+23
        check("tmo_done_pre", 32'(b_done), 0);
        tick();                              // k+24
        check("tmo_done",     32'(b_done), 1);
        check("tmo_sticky",   32'(b_tmo),  1);
        b_tmo_clr = 1'b1;
        tick();                              // k+25: relaunch of a pending event
        b_tmo_clr = 1'b0;
        check("tmo_cleared",  32'(b_tmo),  0);
        check("tmo_relaunch", 32'(b_req),  1);
        check("tmo_pend",     32'(b_pend), 2);

        // ---------------- reset in REQ_LO on A with ack high ----------------
        a_far_en  = 1'b0;
        a_man_ack = 1'b0;
        tick();
        a_pulse = 1'b1;                      // cycle c
        tick();                              // c+1
        check("rl_req_up", 32'(a_req), 1);
        a_man_ack = 1'b1;                    // second pulse still high
        tick();                              // c+2
        a_pulse = 1'b0;
        check("rl_pend1", 32'(a_pend), 1);
        tick(); tick();                      // c+4
        check("rl_req_c4", 32'(a_req), 1);
        tick();                              // c+5: REQ_LO
        check("rl_req_lo", 32'(a_req),  0);
        check("rl_pend_lo", 32'(a_pend), 1);
        a_reset_ = 1'b0;
        #1;
        check("rl_rst_req",  32'(a_req),  0);
        check("rl_rst_pend", 32'(a_pend), 0);
        check("rl_rst_idle", 32'(a_idle), 0);
        tick();
        a_reset_ = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("rl_init_stuck", 32'(a_idle), 0);
        check("rl_init_req",   32'(a_req),  0);
        a_man_ack = 1'b0;                    // cycle r
        for (int i = 1; i <= SYNC_LAT + 1; i++) begin
            tick();
            check($sformatf("rl_idle_r%0d", i), 32'(a_idle), 32'(i == SYNC_LAT + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_pulse_tx_ctrl.md
Name: cdc_pulse_tx_ctrl

Overview:
Source-side controller for a 4-phase req/ack clock-domain crossing. It collects single-cycle event pulses in the local domain and counts the pending ones. For each pending event it runs one full handshake: req_out is raised, it waits for the acknowledge, req_out is dropped, and it waits for the acknowledge to fall. The asynchronous acknowledge is brought in through one instance of the library 3-stage set-type synchronizer cell p_SSYNC3DO_S_PPP. Because that cell resets to 1, the far side is treated as busy until it is proven idle.

Parameters:
CNT_W, 4, width of the pending-event counter; it saturates at 2^CNT_W-1.
TO_W, 8, width of the handshake watchdog counter; the timeout threshold is 2^TO_W-1 cycles.

Ports:
clk  in  1  core clock
reset_  in  1  asynchronous active-low reset
pulse_in  in  1  local event, one count per asserted cycle
ack_in  in  1  far-domain acknowledge, asynchronous to clk
req_out  out  1  request level to the far domain, driven directly from a flop
done_pulse  out  1  one-cycle strobe when a handshake completes
pend_cnt  out  CNT_W  events accepted but not yet launched
idle  out  1  high when state is IDLE and pend_cnt is 0
ovf  out  1  sticky flag: an event was dropped because the counter was saturated
ovf_clr  in  1  clears ovf
tmo  out  1  sticky flag: the watchdog expired
tmo_clr  in  1  clears tmo

Behaviour:
- Clock and reset: one clock, clk. Reset reset_ is asynchronous and active-low. Every flop, including the synchronizer set_ input, is driven from reset_.
- Reset values: req_out=0, done_pulse=0, pend_cnt=0, ovf=0, tmo=0, idle=0, state=INIT, watchdog=0. Internally, ack_s=1 (synchronizer output).
- ack_s latency: a change on ack_in is visible on ack_s 3 clk edges later. The FSM uses only ack_s.
- States and transitions:
  - INIT: leave when ack_s==0, go to IDLE. This avoids launching into a far side that has not yet reset.
  - IDLE: if (pend_cnt!=0 or pulse_in), go to REQ_HI and set req_out=1 on the same edge. The launch consumes one event.
  - REQ_HI: req_out=1. When ack_s==1, clear req_out and go to REQ_LO.
  - REQ_LO: req_out=0. When ack_s==0, go to IDLE and pulse done_pulse for 1 cycle.
- Back-to-back handshakes: IDLE relaunches on the cycle after done_pulse if events are still pending. Minimum handshake period is about 2x sync latency plus far-side response plus 2 cycles.
- Counter update, per cycle: next = pend_cnt + inc - dec.
  - inc = pulse_in and not saturated.
  - dec = launch.
  - pulse_in together with a launch while pend_cnt==0: the event is launched directly and pend_cnt stays 0.
  - pulse_in while pend_cnt==max and no launch: the event is dropped and ovf is set. If launching in the same cycle, the event is accepted instead (net 0).
- Flag set/clear priority: ovf_clr and a new overflow in the same cycle leave ovf=1 (set wins). The same rule applies to tmo and tmo_clr.
- Watchdog:
  - Counts cycles spent in REQ_HI or REQ_LO; clears on every state change and in IDLE/INIT.
  - On reaching all-ones it sets tmo and holds at all-ones.
  - The handshake is never aborted; the FSM keeps waiting.
- idle is registered (or combinational from flops only). It is low in INIT.
- Reset mid-handshake drops req_out to 0 immediately, empties the counter and returns the FSM to INIT. After reset the block waits for ack_s==0.
- ack_in glitching high in IDLE or INIT is ignored by IDLE. A stuck-high ack_s keeps the block in INIT or REQ_LO.

Decomposition:
- Shared package: the state encoding as a 2-bit enum (INIT=0, IDLE=1, REQ_HI=2, REQ_LO=3) and the SYNC_LAT=3 constant used by the bench.
- Sub-modules: the only one is the existing p_SSYNC3DO_S_PPP instance. The FSM, counter and watchdog stay flat in this module, with no new sub-module.

Test Plan:
- Reset with ack_in=0: req_out=0, idle=0 for 3 cycles, then state goes to IDLE; idle=1 at cycle 4 after reset release.
- Single handshake: pulse_in at cycle t; far model raises ack 2 cycles after seeing req, drops ack 2 cycles after req falls. Required: req_out=1 at t+1, req_out=0 at t+7, done_pulse exactly once at t+13, pend_cnt stays 0.
- Burst: 5 consecutive pulse_in cycles while IDLE. Required: pend_cnt peaks at 4, exactly 5 req_out rising edges, 5 done_pulses, ovf=0, final idle=1.
- Overflow with CNT_W=2: ack_in held 0, so handshakes stall in REQ_HI; apply 6 pulses. Required: 1 launched, pend_cnt=3, ovf=1. ovf_clr in the same cycle as a 7th pulse keeps ovf=1; a later lone ovf_clr clears it.
- Timeout with TO_W=4: ack_in held 0 after launch. Required: tmo=1 exactly 15 cycles after entering REQ_HI, and req_out is still 1. Then raise ack_in: the handshake completes normally; tmo_clr clears tmo.
- Reset in REQ_LO with ack_in=1: req_out=0 and pend_cnt=0 immediately. The block stays in INIT until ack_in=0 and 3 more cycles have passed.
